// File: rtl/rv_fetch.sv
// rv_fetch: PC generation, single-outstanding instruction bus reads, decode buffer.
// Define RV_FETCH_PREFETCH_EN for a 2-entry buffer with back-to-back fetch.
module rv_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          ADDR_W       = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic [ADDR_W-1:0] i_pc_target,
    output logic              o_bus_req,
    output logic [ADDR_W-1:0] o_bus_addr,
    input  logic              i_bus_ack,
    input  logic [31:0]       i_bus_rdata,
    output logic              o_fetch_ack,
    output logic [31:0]       o_instr,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_pc_plus4
);

`ifdef RV_FETCH_PREFETCH_EN
    localparam logic [1:0] DEPTH = 2'd2;
`else
    localparam logic [1:0] DEPTH = 2'd1;
`endif

    localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(3);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] drain_addr;
    logic [1:0]        count;
    logic [1:0]        count_nx;
    logic              push;
    logic              pop;
    logic [31:0]       head_instr;
    logic [ADDR_W-1:0] head_pc;
`ifdef RV_FETCH_PREFETCH_EN
    logic [31:0]       tail_instr;
    logic [ADDR_W-1:0] tail_pc;
`endif

    always_comb begin
        push     = (state == REQ) && i_bus_ack && !i_flush;
        pop      = (count != 2'd0) && !i_stall && !i_flush;
        count_nx = count + {1'b0, push} - {1'b0, pop};
        state_nx = state;
        unique case (state)
            IDLE: state_nx = REQ;
            REQ: begin
                if (i_flush)
                    state_nx = i_bus_ack ? REQ : DRAIN;
                else if (i_bus_ack)
                    state_nx = (count_nx < DEPTH) ? REQ : HOLD;
            end
            HOLD: begin
                if (i_flush || pop)
                    state_nx = REQ;
            end
            // An ack here retires the orphaned read even if another flush lands
            DRAIN: begin
                if (i_bus_ack)
                    state_nx = REQ;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pc       <= RESET_VECTOR[ADDR_W-1:0];
            drain_addr <= '0;
            count      <= 2'd0;
        end else begin
            if (i_flush)
                r_pc <= i_pc_target & ALIGN;
            else if (push)
                r_pc <= r_pc + ADDR_W'(4);
            // The bus cannot abort, so the pending address is kept until ack
            if (state == REQ && i_flush && !i_bus_ack)
                drain_addr <= r_pc;
            count <= i_flush ? 2'd0 : count_nx;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            head_instr <= '0;
            head_pc    <= '0;
`ifdef RV_FETCH_PREFETCH_EN
            tail_instr <= '0;
            tail_pc    <= '0;
`endif
        end else begin
`ifdef RV_FETCH_PREFETCH_EN
            if (pop && count == 2'd2) begin
                head_instr <= tail_instr;
                head_pc    <= tail_pc;
            end
            if (push) begin
                if (count == 2'd0 || (count == 2'd1 && pop)) begin
                    head_instr <= i_bus_rdata;
                    head_pc    <= r_pc;
                end else begin
                    tail_instr <= i_bus_rdata;
                    tail_pc    <= r_pc;
                end
            end
`else
            if (push) begin
                head_instr <= i_bus_rdata;
                head_pc    <= r_pc;
            end
`endif
        end
    end

    assign o_bus_req   = (state == REQ) || (state == DRAIN);
    assign o_bus_addr  = (state == DRAIN) ? drain_addr : r_pc;
    assign o_fetch_ack = (count != 2'd0);
    assign o_instr     = head_instr;
    assign o_pc        = head_pc;
    assign o_pc_plus4  = head_pc + ADDR_W'(4);

endmodule

// File: doc/rv_fetch.md
Name: rv_fetch

Overview:
Instruction fetch unit of the pipelined core, sitting between the instruction bus and the decode stage. It keeps the PC, issues single-outstanding word reads, and buffers returned instructions for decode. It obeys the stall and redirect signals from the pipeline control block, and returns the fetch-valid/ack indication that the control block uses for decode stalling. On a redirect it discards any in-flight response.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
ADDR_W, 32, PC/bus address width.

Ports:
i_clk  in  1  clock, all state on rising edge
i_reset  in  1  asynchronous, active-high reset
i_stall  in  1  decode not accepting; holds the buffer head
i_flush  in  1  redirect (branch/jump taken in execute)
i_pc_target  in  ADDR_W  redirect target, sampled when i_flush=1
o_bus_req  out  1  instruction read request (cyc+stb)
o_bus_addr  out  ADDR_W  word address of request, [1:0]=0
i_bus_ack  in  1  read data valid, one-cycle pulse
i_bus_rdata  in  32  instruction word
o_fetch_ack  out  1  buffer head valid (feeds control block fetch ack)
o_instr  out  32  buffer head instruction
o_pc  out  ADDR_W  PC of o_instr
o_pc_plus4  out  ADDR_W  o_pc+4, wraps mod 2^ADDR_W

Behaviour:
- Reset (async): state=IDLE, r_pc=RESET_VECTOR, buffer empty, o_bus_req=0, o_fetch_ack=0, o_instr=0, o_pc=0. Reset mid-transaction drops o_bus_req immediately; a late ack after reset release is ignored (state IDLE).
- States: IDLE, REQ, HOLD, DRAIN.
- IDLE -> REQ one cycle after reset release.
- REQ: o_bus_req=1, o_bus_addr=r_pc, both stable until i_bus_ack.
  - On ack, no flush: push {rdata, r_pc} and set r_pc+=4 (wrap).
  - Then stay in REQ, with req held and the new address driven next cycle, if the buffer has room after this cycle's push and pop. Otherwise go to HOLD (req=0).
- HOLD: o_bus_req=0. Go to REQ in the cycle after a pop frees an entry.
- Pop: o_fetch_ack & !i_stall. The head leaves and the next entry becomes head in the next cycle.
- Push and pop in the same cycle are legal at any occupancy, including full.
- Flush has top priority over push, pop and stall:
  - Buffer is cleared at once; o_fetch_ack=0 next cycle.
  - r_pc <= {i_pc_target[ADDR_W-1:2], 2'b00}.
  - If in REQ with no ack this cycle: go to DRAIN. The bus cannot abort, so req and the old address stay held until ack; that data is discarded, then go to REQ at the new PC.
  - If ack arrives in the same cycle as flush: discard the data and go to REQ at the target.
  - Flush from IDLE or HOLD: go to REQ at the target.
  - Flush during DRAIN: update r_pc only, stay in DRAIN.
- Latency: zero-wait bus gives req in cycle 1 after reset release, ack in cycle 1, o_fetch_ack in cycle 2. Sustained throughput is 1 instr/cycle only with prefetch enabled.
- At most one outstanding request. o_bus_req is never asserted in HOLD.

Optional Feature:
RV_FETCH_PREFETCH_EN
- Defined: buffer depth 2. A request is issued while one entry is held, giving back-to-back fetch under zero-wait ack.
- Undefined: buffer depth 1. Leave REQ after every ack unless a pop occurs in the same cycle. Max 1 instr per 2 cycles unless decode pops on every ack.

Test Plan:
- Reset release with RESET_VECTOR=0x100 and ack every cycle → addr 0x100,0x104,0x108; o_pc follows in order; o_pc_plus4=o_pc+4; o_fetch_ack first high in cycle 2.
- i_stall=1 for 5 cycles with the buffer full → req=0 (HOLD), o_instr/o_pc stable; on stall release the next request goes out at the following PC.
- Flush to 0x2002 while req pending at 0x108, ack 3 cycles later with 0xDEADBEEF → data discarded, next request addr 0x2000, o_pc=0x2000.
- Flush in the same cycle as ack → acked data is not delivered and the next request addr is the target.
- PC=0xFFFF_FFFC fetched → next addr 0x0000_0000, o_pc_plus4=0.
- Async reset asserted mid-REQ → o_bus_req=0 and o_fetch_ack=0 with no clock edge; a stale ack after release is ignored.
